// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the controller state encoding and default operand width.
package serial_sub_pkg;

  localparam int DEF_WIDTH = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_cell.sv
// One-bit full-difference cell used once per serial step.
// Produces the difference bit and the borrow into the next bit.
module diff_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one difference bit per RUN cycle, LSB first.
// Results update only when DONE is entered and hold until the next DONE.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             neq
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             bin;
  logic             neq_acc;
  logic             d;
  logic             bout;
  logic             last;

  diff_bit_cell u_cell (
    .a    (xs[0]),
    .b    (ys[0]),
    .bin  (bin),
    .d    (d),
    .bout (bout)
  );

  assign last = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xs      <= '0;
      ys      <= '0;
      res     <= '0;
      cnt     <= '0;
      bin     <= 1'b0;
      neq_acc <= 1'b0;
      diff    <= '0;
      borrow  <= 1'b0;
      neq     <= 1'b0;
    end else if (state == IDLE && start) begin
      xs      <= x;
      ys      <= y;
      cnt     <= '0;
      bin     <= 1'b0;
      neq_acc <= 1'b0;
    end else if (state == RUN) begin
      res     <= {d, res[WIDTH-1:1]};
      bin     <= bout;
      neq_acc <= neq_acc | (xs[0] ^ ys[0]);
      xs      <= xs >> 1;
      ys      <= ys >> 1;
      cnt     <= cnt + 1'b1;
      // Final bit goes straight to the outputs on the edge into DONE.
      if (last) begin
        diff   <= {d, res[WIDTH-1:1]};
        borrow <= bout;
        neq    <= neq_acc | (xs[0] ^ ys[0]);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at the default width of 5.
// Each scenario task drives vectors and checks hand-computed results.
module tb_serial_sub_ctrl;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         neq;

  int total = 0;
  int bad = 0;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .y      (y),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .neq    (neq)
  );

  always #5 clk = ~clk;

  // Called at the negedge of cycle T+1; lat is the cycle offset of done.
  task automatic wait_done(output int lat, output int nbusy);
    int n;
    n = 1;
    lat = -1;
    nbusy = 0;
    while (n <= 20 && lat < 0) begin
      if (done === 1'b1) lat = n;
      else begin
        if (busy === 1'b1) nbusy++;
        @(posedge clk);
        @(negedge clk);
        n++;
      end
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int nbusy);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    x = a;
    y = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, nbusy);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctl busy=%b done=%b want 0 0", busy, done);
    end
    total++;
    if (diff !== 5'b00000 || borrow !== 1'b0 || neq !== 1'b0) begin
      bad++;
      $display("FAIL reset_out diff=%b borrow=%b neq=%b want 00000 0 0",
               diff, borrow, neq);
    end
    rst = 1'b0;
  endtask

  task automatic check_op(input string nm,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ed, input logic eb,
                          input logic en);
    int lat, nb;
    do_op(a, b, lat, nb);
    total++;
    if (lat !== 6 || nb !== 5) begin
      bad++;
      $display("FAIL %s_lat lat=%0d busy_cycles=%0d want 6 5", nm, lat, nb);
    end
    total++;
    if (diff !== ed || borrow !== eb || neq !== en) begin
      bad++;
      $display("FAIL %s_res diff=%b borrow=%b neq=%b want %b %b %b",
               nm, diff, borrow, neq, ed, eb, en);
    end
  endtask

  task automatic test_basic;
    check_op("basic", 5'b00101, 5'b00010, 5'b00011, 1'b0, 1'b1);
  endtask

  task automatic test_borrow;
    check_op("borrow_a", 5'b00010, 5'b00101, 5'b11101, 1'b1, 1'b1);
    check_op("borrow_b", 5'b00000, 5'b00001, 5'b11111, 1'b1, 1'b1);
  endtask

  task automatic test_equal;
    check_op("equal", 5'b10110, 5'b10110, 5'b00000, 1'b0, 1'b0);
    check_op("msb", 5'b10000, 5'b00100, 5'b01100, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back;
    logic eb, ed;
    int m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    x = 5'b00111;
    y = 5'b00011;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      m = n % 7;
      eb = (m >= 1 && m <= 5);
      ed = (m == 6);
      total++;
      if (busy !== eb || done !== ed) begin
        bad++;
        $display("FAIL b2b_c%0d busy=%b done=%b want %b %b",
                 n, busy, done, eb, ed);
      end
    end
    start = 1'b0;
    total++;
    if (diff !== 5'b00100 || borrow !== 1'b0 || neq !== 1'b1) begin
      bad++;
      $display("FAIL b2b_res diff=%b borrow=%b neq=%b want 00100 0 1",
               diff, borrow, neq);
    end
  endtask

  task automatic test_abort;
    int seen;
    check_op("pre_abort", 5'b00101, 5'b00010, 5'b00011, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    x = 5'b10110;
    y = 5'b00001;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || diff !== 5'b00011) begin
      bad++;
      $display("FAIL run_hold busy=%b diff=%b want 1 00011", busy, diff);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 5'b00000 ||
        borrow !== 1'b0 || neq !== 1'b0) begin
      bad++;
      $display("FAIL abort busy=%b done=%b diff=%b borrow=%b neq=%b want 0 0 00000 0 0",
               busy, done, diff, borrow, neq);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort_quiet active_cycles=%0d want 0", seen);
    end
  endtask

  task automatic test_late_change;
    int lat, nb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    x = 5'b01111;
    y = 5'b01000;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    x = 5'b11111;
    y = 5'b11111;
    wait_done(lat, nb);
    total++;
    if (lat !== 6 || diff !== 5'b00111 || borrow !== 1'b0 || neq !== 1'b1) begin
      bad++;
      $display("FAIL late lat=%0d diff=%b borrow=%b neq=%b want 6 00111 0 1",
               lat, diff, borrow, neq);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_borrow;
    test_equal;
    test_back_to_back;
    test_abort;
    test_late_change;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, setting the operand and result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin one subtraction, sampled only in IDLE.
REQ-005 The block SHALL have port x, input, WIDTH, the minuend, sampled on the accepted start cycle.
REQ-006 The block SHALL have port y, input, WIDTH, the subtrahend, sampled on the accepted start cycle.
REQ-007 The block SHALL have port busy, output, 1, high while an operation is in RUN.
REQ-008 The block SHALL have port done, output, 1, a one-cycle pulse marking that the result outputs were updated.
REQ-009 The block SHALL have port diff, output, WIDTH, the result (x - y) mod 2^WIDTH.
REQ-010 The block SHALL have port borrow, output, 1, the final borrow-out, 1 when unsigned x < y.
REQ-011 The block SHALL have port neq, output, 1, which is 1 when x != y.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL latch x and y into internal shift registers, clear the internal borrow and neq accumulators, zero the bit counter and go to RUN.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-015 In each RUN cycle, the block SHALL pass LSB a and LSB b of the shift registers and the borrow register bin through one full-difference cell: d = a^b^bin, bout = (~a&b) | (~(a^b)&bin).
REQ-016 In each RUN cycle, the block SHALL shift d into the MSB of an internal result register (right shift), register bout as the next bin, OR (a^b) into the neq accumulator, shift both operand registers right and increment the counter.
REQ-017 When the counter equals WIDTH-1 in RUN, the block SHALL go to DONE after that cycle's bit is processed, so exactly WIDTH bit cycles occur.
REQ-018 On the clock edge entering DONE, the block SHALL copy the internal result, final borrow and neq accumulator to diff, borrow and neq.
REQ-019 In DONE, the block SHALL assert done for exactly one cycle and return to IDLE unconditionally.
REQ-020 Latency: if start is accepted in cycle T, done SHALL be high in cycle T+WIDTH+1 and busy SHALL be high in cycles T+1..T+WIDTH.
REQ-021 The block SHALL ignore start while in RUN or DONE; a start held high continuously SHALL begin a new operation only when the FSM is back in IDLE.
REQ-022 diff, borrow and neq SHALL hold their last values from DONE until the next DONE and SHALL NOT change during RUN.
REQ-023 Changes on x and y after the accepted start cycle SHALL NOT affect the result.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL go to IDLE with busy=0, done=0, diff=0, borrow=0, neq=0, and all internal registers cleared.
REQ-025 rst SHALL take priority over start.
REQ-026 When rst=1 during RUN or DONE, the block SHALL abort the operation with no done pulse.

Structure
REQ-027 The FSM state enumeration (IDLE, RUN, DONE) and the default width constant SHALL be defined in a shared package, serial_sub_pkg.
REQ-028 The per-bit logic SHALL be one combinational sub-module, diff_bit_cell (inputs a, b, bin; outputs d, bout), instantiated once.
REQ-029 Counter width SHALL be clog2(WIDTH) bits.

Verification
REQ-030 The bench SHALL cover: x=00101, y=00010, start pulse in cycle T -> done in cycle T+6; diff=00011, borrow=0, neq=1.
REQ-031 The bench SHALL cover: x=00010, y=00101 -> diff=11101, borrow=1, neq=1; and x=00000, y=00001 -> diff=11111, borrow=1.
REQ-032 The bench SHALL cover: x=y=10110 -> diff=00000, borrow=0, neq=0; and x=10000, y=00100 -> diff=01100, borrow=0, neq=1.
REQ-033 The bench SHALL cover: start held high for 20 cycles with fixed operands -> done pulses at T+6, T+13 and T+20, and busy=0 in each DONE and IDLE cycle.
REQ-034 The bench SHALL cover: rst=1 in the third RUN cycle after a completed result of 00011 -> next cycle busy=0, done=0, diff=00000, borrow=0, neq=0, and no done pulse follows.
REQ-035 The bench SHALL cover: x and y changed to 11111 one cycle after start, with original operands 01111 and 01000 -> diff=00111, borrow=0.
